small_bpf: RTL and testbench



---
 rtl/small_bpf.sv | 91 +++++++++
 tb/tb_small_bpf.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/small_bpf.sv
`timescale 1ns/1ps
// Shift-only second-order state-variable filter: band-pass, band-stop and high-pass outputs.
// Define SMALL_BPF_ROUND_EN to round the integrator taps half-up instead of truncating.
module small_bpf #(
    parameter int K0_SHIFT = 6,
    parameter int K1_SHIFT = 6,
    parameter int WIDTH    = 16,
    parameter int CLAMP    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] dataIn,
    output logic signed [WIDTH-1:0] bpfOut,
    output logic signed [WIDTH-1:0] bsfOut,
    output logic signed [WIDTH-1:0] hpfOut
);

    localparam int A0W = WIDTH + K0_SHIFT;
    localparam int A1W = WIDTH + K1_SHIFT;
    localparam int EW  = WIDTH + 2;

    localparam logic signed [EW-1:0] W_MAX = EW'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [EW-1:0] W_MIN = ~W_MAX;

`ifdef SMALL_BPF_ROUND_EN
    localparam logic signed [A0W:0] RND0 = (A0W + 1)'(1) << (K0_SHIFT - 1);
    localparam logic signed [A1W:0] RND1 = (A1W + 1)'(1) << (K1_SHIFT - 1);
`else
    localparam logic signed [A0W:0] RND0 = '0;
    localparam logic signed [A1W:0] RND1 = '0;
`endif

    logic signed [A0W-1:0] acc0, acc0_nxt;
    logic signed [A1W-1:0] acc1, acc1_nxt;
    logic signed [A0W:0]   acc0_r, sum0;
    logic signed [A1W:0]   acc1_r, sum1;
    logic signed [EW-1:0]  din_e, bp, lp, hp, bs;
    logic                  unused_lsbs;

    // Taking the bits above the shift amount is the arithmetic right shift.
    assign acc0_r = (A0W + 1)'(acc0) + RND0;
    assign acc1_r = (A1W + 1)'(acc1) + RND1;
    assign bp     = EW'(signed'(acc0_r[A0W:K0_SHIFT]));
    assign lp     = EW'(signed'(acc1_r[A1W:K1_SHIFT]));
    assign unused_lsbs = ^{acc0_r[K0_SHIFT-1:0], acc1_r[K1_SHIFT-1:0]};

    assign din_e = EW'(dataIn);
    assign hp    = din_e - lp - bp;
    assign bs    = din_e - bp;

    assign sum0 = (A0W + 1)'(acc0) + (A0W + 1)'(hp);
    assign sum1 = (A1W + 1)'(acc1) + (A1W + 1)'(bp);

    always_comb begin
        acc0_nxt = sum0[A0W-1:0];
        acc1_nxt = sum1[A1W-1:0];
        if (CLAMP != 0) begin
            if (sum0[A0W] != sum0[A0W-1])
                acc0_nxt = sum0[A0W] ? {1'b1, {(A0W-1){1'b0}}} : {1'b0, {(A0W-1){1'b1}}};
            if (sum1[A1W] != sum1[A1W-1])
                acc1_nxt = sum1[A1W] ? {1'b1, {(A1W-1){1'b0}}} : {1'b0, {(A1W-1){1'b1}}};
        end
    end

    function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [EW-1:0] v);
        if (v > W_MAX)
            return {1'b0, {(WIDTH-1){1'b1}}};
        else if (v < W_MIN)
            return {1'b1, {(WIDTH-1){1'b0}}};
        else
            return v[WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc0   <= '0;
            acc1   <= '0;
            bpfOut <= '0;
            bsfOut <= '0;
            hpfOut <= '0;
        end else if (en) begin
            acc0   <= acc0_nxt;
            acc1   <= acc1_nxt;
            bpfOut <= sat_w(bp);
            bsfOut <= sat_w(bs);
            hpfOut <= sat_w(hp);
        end
    end

endmodule

// File: tb/tb_small_bpf.sv
`timescale 1ns/1ps
// Directed bench for small_bpf: saturating and wrapping instances driven in parallel.
module tb_small_bpf;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic signed [15:0] din = '0;
    logic signed [15:0] bp_c, bs_c, hp_c, bp_w, bs_w, hp_w;

    int vectors = 0;
    int miscompares = 0;

    longint m_a0, m_a1;
    int     m_bp, m_bs, m_hp;

    always #5 clk = ~clk;

    small_bpf #(.K0_SHIFT(6), .K1_SHIFT(6), .WIDTH(16), .CLAMP(1)) u_clamp (
        .clk(clk), .rst(rst), .en(en), .dataIn(din),
        .bpfOut(bp_c), .bsfOut(bs_c), .hpfOut(hp_c));

    small_bpf #(.K0_SHIFT(6), .K1_SHIFT(6), .WIDTH(16), .CLAMP(0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .dataIn(din),
        .bpfOut(bp_w), .bsfOut(bs_w), .hpfOut(hp_w));

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference for the saturating K=6 instance, written in plain integer arithmetic.
    function automatic longint shr_k(input longint a);
`ifdef SMALL_BPF_ROUND_EN
        return (a + 64'sd32) >>> 6;
`else
        return a >>> 6;
`endif
    endfunction

    function automatic int sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic longint clamp22(input longint v);
        if (v > 2097151) return 2097151;
        if (v < -2097152) return -2097152;
        return v;
    endfunction

    task automatic model_reset();
        m_a0 = 0; m_a1 = 0; m_bp = 0; m_bs = 0; m_hp = 0;
    endtask

    task automatic model_step(input int x);
        longint b, l, h;
        b = shr_k(m_a0);
        l = shr_k(m_a1);
        h = longint'(x) - l - b;
        m_bp = sat16(b);
        m_hp = sat16(h);
        m_bs = sat16(longint'(x) - b);
        m_a0 = clamp22(m_a0 + h);
        m_a1 = clamp22(m_a1 + b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        en = 1'b0;
        #2 rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            din = 16'($urandom);
            en  = 1'($urandom_range(0, 1));
            tick();
            vectors++;
            if ({bp_c, bs_c, hp_c, bp_w, bs_w, hp_w} !== 96'd0) begin
                miscompares++;
                $display("FAIL reset_hold: bp=%0d bs=%0d hp=%0d wrap bp=%0d bs=%0d hp=%0d, required all 0",
                         bp_c, bs_c, hp_c, bp_w, bs_w, hp_w);
            end
        end
        #2 rst = 1'b1;
        din = 16'sd0;
        en  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if ({bp_c, bs_c, hp_c, bp_w, bs_w, hp_w} !== 96'd0) begin
                miscompares++;
                $display("FAIL reset_zero_in: bp=%0d bs=%0d hp=%0d, required all 0", bp_c, bs_c, hp_c);
            end
        end
    endtask

    task automatic test_dc_step();
        apply_reset();
        en  = 1'b1;
        din = 16'sd1000;
        tick();
        vectors++;
        if (hp_c !== 16'sd1000 || bs_c !== 16'sd1000 || bp_c !== 16'sd0) begin
            miscompares++;
            $display("FAIL dc_first_edge: hp=%0d bs=%0d bp=%0d, required 1000 1000 0", hp_c, bs_c, bp_c);
        end
        vectors++;
        if (hp_w !== 16'sd1000 || bs_w !== 16'sd1000 || bp_w !== 16'sd0) begin
            miscompares++;
            $display("FAIL dc_first_edge_wrap: hp=%0d bs=%0d bp=%0d, required 1000 1000 0", hp_w, bs_w, bp_w);
        end
        for (int i = 1; i < 20000; i++) tick();
        vectors++;
        if (hp_c < -16'sd2 || hp_c > 16'sd2) begin
            miscompares++;
            $display("FAIL dc_hp_settle: hp=%0d, required -2..2", hp_c);
        end
        vectors++;
        if (bp_c < -16'sd2 || bp_c > 16'sd2) begin
            miscompares++;
            $display("FAIL dc_bp_settle: bp=%0d, required -2..2", bp_c);
        end
        vectors++;
        if (bs_c < 16'sd998 || bs_c > 16'sd1002) begin
            miscompares++;
            $display("FAIL dc_bs_settle: bs=%0d, required 998..1002", bs_c);
        end
    endtask

    task automatic test_nyquist();
        int pk_hp, pk_bp, a;
        pk_hp = 0;
        pk_bp = 0;
        apply_reset();
        en = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            din = (i % 2 == 1) ? -16'sd8000 : 16'sd8000;
            tick();
            if (i >= 19000) begin
                a = int'(hp_c); if (a < 0) a = -a; if (a > pk_hp) pk_hp = a;
                a = int'(bp_c); if (a < 0) a = -a; if (a > pk_bp) pk_bp = a;
            end
        end
        vectors++;
        if (pk_hp < 7600 || pk_hp > 8400) begin
            miscompares++;
            $display("FAIL nyquist_hp_peak: peak=%0d, required 7600..8400", pk_hp);
        end
        vectors++;
        if (pk_bp >= 300) begin
            miscompares++;
            $display("FAIL nyquist_bp_peak: peak=%0d, required < 300", pk_bp);
        end
    endtask

    task automatic test_enable_hold();
        apply_reset();
        for (int i = 0; i < 200; i++) begin
            if (i >= 100 && i < 150) begin
                en  = 1'b0;
                din = 16'($urandom);
            end else begin
                en  = 1'b1;
                din = 16'sd1000;
            end
            tick();
            if (en) model_step(1000);
            vectors++;
            if (bp_c !== m_bp[15:0] || bs_c !== m_bs[15:0] || hp_c !== m_hp[15:0]) begin
                miscompares++;
                $display("FAIL enable_hold cyc %0d en=%0b: bp=%0d bs=%0d hp=%0d, required %0d %0d %0d",
                         i, en, bp_c, bs_c, hp_c, m_bp, m_bs, m_hp);
            end
        end
    endtask

    task automatic test_clamp();
        int jc, jw, d, bs_max, bs_min;
        logic signed [15:0] p_hc, p_bc, p_hw, p_bw;
        jc = 0; jw = 0; bs_max = -40000; bs_min = 40000;
        p_hc = '0; p_bc = '0; p_hw = '0; p_bw = '0;
        apply_reset();
        en = 1'b1;
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 5000; i++) begin
                din = (ph == 0) ? 16'sd32767 : -16'sd32768;
                tick();
                if (i > 0) begin
                    d = int'(hp_c) - int'(p_hc); if (d < 0) d = -d; if (d > jc) jc = d;
                    d = int'(bp_c) - int'(p_bc); if (d < 0) d = -d; if (d > jc) jc = d;
                    d = int'(hp_w) - int'(p_hw); if (d < 0) d = -d; if (d > jw) jw = d;
                    d = int'(bp_w) - int'(p_bw); if (d < 0) d = -d; if (d > jw) jw = d;
                end
                if (ph == 0 && int'(bs_c) > bs_max) bs_max = int'(bs_c);
                if (ph == 1 && int'(bs_c) < bs_min) bs_min = int'(bs_c);
                p_hc = hp_c; p_bc = bp_c; p_hw = hp_w; p_bw = bp_w;
            end
        end
        vectors++;
        if (jc >= 16384) begin
            miscompares++;
            $display("FAIL clamp_no_jump: max step=%0d, required < 16384", jc);
        end
        vectors++;
        if (jw <= 16384) begin
            miscompares++;
            $display("FAIL wrap_shows_jump: max step=%0d, required > 16384", jw);
        end
        vectors++;
        if (bs_max != 32767) begin
            miscompares++;
            $display("FAIL clamp_bs_max: max=%0d, required 32767", bs_max);
        end
        vectors++;
        if (bs_min < -32768 || bs_min > -32766) begin
            miscompares++;
            $display("FAIL clamp_bs_min: min=%0d, required -32768..-32766", bs_min);
        end
    endtask

    task automatic test_async_reset();
        int half, cnt;
        logic signed [15:0] lvl;
        half = 40; cnt = 0; lvl = 16'sd10000;
        apply_reset();
        en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            din = lvl;
            tick();
            cnt++;
            if (cnt >= half) begin
                cnt = 0;
                lvl = -lvl;
                if (half > 2) half--;
            end
        end
        #3 rst = 1'b0;
        #1;
        vectors++;
        if ({bp_c, bs_c, hp_c, bp_w, bs_w, hp_w} !== 96'd0) begin
            miscompares++;
            $display("FAIL async_reset_immediate: bp=%0d bs=%0d hp=%0d wrap bp=%0d bs=%0d hp=%0d, required all 0",
                     bp_c, bs_c, hp_c, bp_w, bs_w, hp_w);
        end
        for (int i = 0; i < 3; i++) begin
            din = 16'($urandom);
            tick();
            vectors++;
            if ({bp_c, bs_c, hp_c, bp_w, bs_w, hp_w} !== 96'd0) begin
                miscompares++;
                $display("FAIL async_reset_held: bp=%0d bs=%0d hp=%0d, required all 0", bp_c, bs_c, hp_c);
            end
        end
        #2 rst = 1'b1;
        din = 16'sd1234;
        tick();
        vectors++;
        if (hp_c !== 16'sd1234 || bs_c !== 16'sd1234 || bp_c !== 16'sd0) begin
            miscompares++;
            $display("FAIL async_reset_resume: hp=%0d bs=%0d bp=%0d, required 1234 1234 0", hp_c, bs_c, bp_c);
        end
        vectors++;
        if (hp_w !== 16'sd1234 || bs_w !== 16'sd1234 || bp_w !== 16'sd0) begin
            miscompares++;
            $display("FAIL async_reset_resume_wrap: hp=%0d bs=%0d bp=%0d, required 1234 1234 0", hp_w, bs_w, bp_w);
        end
    endtask

    initial begin
        test_reset();
        test_dc_step();
        test_nyquist();
        test_enable_hold();
        test_clamp();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
